// File: rtl/fetch_pkg.sv
// Shared types and constants for the row-fetch / column-stream engine.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        STREAM,
        FIN
    } fetch_state_e;

    localparam logic MODE_COL = 1'b0;
    localparam logic MODE_ROW = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fetch_row_buf.sv
// Row buffer: one write port, combinational lane-slice (column) and full-row reads.
module fetch_row_buf
    import fetch_pkg::*;
#(
    parameter int NUM_ROWS   = 9,
    parameter int DATA_WIDTH = 64,
    parameter int LANE_W     = 8,
    parameter int WADDR_W    = 4,
    parameter int SEL_W      = 4
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [WADDR_W-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [SEL_W-1:0]             lane_sel,
    input  logic [SEL_W-1:0]             raddr,
    output logic [NUM_ROWS*LANE_W-1:0]   col_data,
    output logic [DATA_WIDTH-1:0]        row_data
);

    localparam int LANES = DATA_WIDTH / LANE_W;

    logic [DATA_WIDTH-1:0] mem [NUM_ROWS];

    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (we && (waddr == WADDR_W'(r))) begin
                mem[r] <= wdata;
            end
        end
    end

    // Lane k of every row, row 0 landing in the LSBs of the column vector.
    always_comb begin
        col_data = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_sel == SEL_W'(k)) begin
                for (int r = 0; r < NUM_ROWS; r++) begin
                    col_data[r*LANE_W +: LANE_W] = mem[r][k*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_comb begin
        row_data = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (raddr == SEL_W'(r)) begin
                row_data = mem[r];
            end
        end
    end

endmodule

// File: rtl/fetch_stream.sv
// Fetches NUM_ROWS words over Avalon-MM, then streams them column-wise (or row-major)
// over a valid/ready interface with backpressure.
module fetch_stream
    import fetch_pkg::*;
#(
    parameter  int NUM_ROWS   = 9,
    parameter  int DATA_WIDTH = 64,
    parameter  int LANE_W     = 8,
    parameter  int ADDR_W     = 4,
    localparam int OUT_W      = max_int(NUM_ROWS * LANE_W, DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic                  mode,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    input  logic [DATA_WIDTH-1:0] avm_readdata,
    input  logic                  avm_readdatavalid,
    input  logic                  avm_waitrequest,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic                  out_last
);

    localparam int LANES  = DATA_WIDTH / LANE_W;
    localparam int ROW_W  = $clog2(NUM_ROWS + 1);
    localparam int BEAT_W = $clog2(max_int(LANES, NUM_ROWS) + 1);
    localparam int COL_W  = NUM_ROWS * LANE_W;

    if (DATA_WIDTH % LANE_W != 0) begin : g_lane_check
        $error("DATA_WIDTH must be a multiple of LANE_W");
    end

    fetch_state_e          state_q, state_d;
    logic [ROW_W-1:0]      row_q;
    logic [BEAT_W-1:0]     beat_q;
    logic [ADDR_W-1:0]     base_q;
    logic                  mode_q;
    logic                  last_beat;
    logic                  row_we;
    logic [BEAT_W-1:0]     lane_sel;
    logic [COL_W-1:0]      col_data;
    logic [DATA_WIDTH-1:0] row_data;

    // MSB lane goes out first in column mode.
    assign lane_sel  = BEAT_W'(LANES - 1) - beat_q;
    assign last_beat = (mode_q == MODE_ROW) ? (beat_q == BEAT_W'(NUM_ROWS - 1))
                                            : (beat_q == BEAT_W'(LANES - 1));
    assign row_we    = (state_q == RESP) && avm_readdatavalid;

    fetch_row_buf #(
        .NUM_ROWS   (NUM_ROWS),
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_W     (LANE_W),
        .WADDR_W    (ROW_W),
        .SEL_W      (BEAT_W)
    ) u_row_buf (
        .clk      (clk),
        .we       (row_we),
        .waddr    (row_q),
        .wdata    (avm_readdata),
        .lane_sel (lane_sel),
        .raddr    (beat_q),
        .col_data (col_data),
        .row_data (row_data)
    );

    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        done        = 1'b0;
        avm_read    = 1'b0;
        avm_address = '0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;
        case (state_q)
            IDLE: begin
                if (start) state_d = REQ;
            end
            REQ: begin
                busy        = 1'b1;
                avm_read    = 1'b1;
                avm_address = base_q + ADDR_W'(row_q);
                if (!avm_waitrequest) state_d = RESP;
            end
            RESP: begin
                busy = 1'b1;
                if (avm_readdatavalid) begin
                    state_d = (row_q == ROW_W'(NUM_ROWS - 1)) ? STREAM : REQ;
                end
            end
            STREAM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = last_beat;
                out_data  = (mode_q == MODE_ROW) ? OUT_W'(row_data) : OUT_W'(col_data);
                if (out_ready && last_beat) state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            beat_q  <= '0;
            base_q  <= '0;
            mode_q  <= MODE_COL;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        mode_q <= mode;
                        row_q  <= '0;
                        beat_q <= '0;
                    end
                end
                RESP: begin
                    if (avm_readdatavalid) row_q <= row_q + 1'b1;
                end
                STREAM: begin
                    if (out_ready && !last_beat) beat_q <= beat_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stream.sv
// Bench for fetch_stream: Avalon slave model, stream sink with a reference beat queue,
// directed vector table, corner-case sequences and randomized jobs.
module tb_fetch_stream;

    localparam int NR = 9;
    localparam int DW = 64;
    localparam int LW = 8;
    localparam int AW = 4;
    localparam int L  = DW / LW;
    localparam int OW = (NR * LW > DW) ? NR * LW : DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          mode;
    logic          busy, done;
    logic [AW-1:0] avm_address;
    logic          avm_read;
    logic [DW-1:0] avm_readdata;
    logic          avm_readdatavalid;
    logic          avm_waitrequest;
    logic          out_valid, out_ready, out_last;
    logic [OW-1:0] out_data;

    fetch_stream dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .base_addr         (base_addr),
        .mode              (mode),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_waitrequest   (avm_waitrequest),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_last          (out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [OW-1:0] data;
        logic          last;
    } beat_t;

    logic [DW-1:0] mem [16];
    beat_t         exp_q[$];
    logic [AW-1:0] addr_q[$];

    task automatic fill_pattern();
        logic [3:0] ah, kh;
        for (int a = 0; a < 16; a++) begin
            for (int k = 0; k < L; k++) begin
                ah = a[3:0];
                kh = k[3:0];
                mem[a][k*LW +: LW] = {ah, kh};
            end
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 16; a++) mem[a] = {$urandom, $urandom};
    endtask

    task automatic push_job(input logic [AW-1:0] b, input logic m);
        beat_t         e;
        logic [DW-1:0] w;
        logic [AW-1:0] a;
        for (int r = 0; r < NR; r++) begin
            a = b + AW'(r);
            addr_q.push_back(a);
        end
        if (m == 1'b0) begin
            for (int bt = 0; bt < L; bt++) begin
                e.data = '0;
                for (int r = 0; r < NR; r++) begin
                    a = b + AW'(r);
                    w = mem[a];
                    e.data[r*LW +: LW] = w[(L-1-bt)*LW +: LW];
                end
                e.last = (bt == L - 1);
                exp_q.push_back(e);
            end
        end else begin
            for (int bt = 0; bt < NR; bt++) begin
                a = b + AW'(bt);
                e.data = OW'(mem[a]);
                e.last = (bt == NR - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // ---------------- Avalon slave ----------------
    int            wait_n = 0;
    int            resp_delay = 0;
    int            n_acc = 0;

    initial begin
        int            stall;
        int            pend_wait;
        logic          pend;
        logic [AW-1:0] pend_addr;
        logic [AW-1:0] held_addr;
        stall = 0; pend = 1'b0; pend_wait = 0; pend_addr = '0; held_addr = '0;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata = '0;
        forever begin
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            if (pend) begin
                if (pend_wait == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = mem[pend_addr];
                    pend = 1'b0;
                end else begin
                    pend_wait--;
                end
            end
            if (avm_read) begin
                if (stall == 0) held_addr = avm_address;
                else chk("addr_stable_in_stall", avm_address, held_addr);
                if (stall < wait_n) begin
                    avm_waitrequest = 1'b1;
                    stall++;
                end else begin
                    avm_waitrequest = 1'b0;
                    stall = 0;
                    pend = 1'b1;
                    pend_wait = resp_delay;
                    pend_addr = avm_address;
                    n_acc++;
                    chk("addr_expected", addr_q.size() != 0, 1'b1);
                    if (addr_q.size() != 0) chk("addr_order", avm_address, addr_q.pop_front());
                end
            end else begin
                if (stall != 0) chk("read_held_in_stall", avm_read, 1'b1);
                avm_waitrequest = 1'b0;
                stall = 0;
            end
        end
    end

    // ---------------- stream sink / monitor ----------------
    logic          rdy_rand = 1'b0;
    logic [3:0]    rdy_pat = 4'hF;
    int            rdy_idx = 0;
    int            n_done = 0;
    int            n_beats = 0;
    int            first_cyc = -1;
    int            start_cyc = 0;
    logic [OW-1:0] first_d = '0, last_d = '0;

    initial begin
        logic          pv, pr, pl, exp_done;
        logic [OW-1:0] pd;
        beat_t         e;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; exp_done = 1'b0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_pat[rdy_idx[1:0]];
            if (out_valid) rdy_idx++;
            if (exp_done) begin
                chk("done_after_last", done, 1'b1);
                chk("busy_low_in_fin", busy, 1'b0);
                exp_done = 1'b0;
            end else if (done) begin
                chk("done_spurious", done, 1'b0);
            end
            if (done) n_done++;
            if (pv && !pr) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, pd);
                chk("hold_last", out_last, pl);
            end
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (out_valid && out_ready) begin
                chk("beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("beat_data", out_data, e.data);
                    chk("beat_last", out_last, e.last);
                    if (n_beats == 0) first_d = out_data;
                    if (e.last) begin
                        last_d = out_data;
                        exp_done = 1'b1;
                    end
                    n_beats++;
                end
            end
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
        end
    end

    // ---------------- main sequencer ----------------
    int n_jobs = 0;

    task automatic launch(input logic [AW-1:0] b, input logic m);
        @(negedge clk); #2;
        base_addr = b;
        mode = m;
        start = 1'b1;
        first_cyc = -1;
        start_cyc = cyc;
        n_beats = 0;
        rdy_idx = 0;
        @(negedge clk); #2;
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk); #2;
            if (done) break;
        end
        chk(name, i < budget, 1'b1);
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic          md;
        int            wn;
        logic [3:0]    pat;
        int            nb;
        int            lat;
        logic [OW-1:0] b0;
        logic [OW-1:0] bl;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int i;
        int acc0;
        int done0;
        tbl[0] = '{base: 4'h0, md: 1'b0, wn: 0, pat: 4'hF, nb: 8, lat: 19,
                   b0: 72'h877767574737271707, bl: 72'h807060504030201000};
        tbl[1] = '{base: 4'h0, md: 1'b0, wn: 3, pat: 4'hF, nb: 8, lat: 0,
                   b0: 72'h877767574737271707, bl: 72'h807060504030201000};
        tbl[2] = '{base: 4'hC, md: 1'b0, wn: 0, pat: 4'hF, nb: 8, lat: 19,
                   b0: 72'h4737271707F7E7D7C7, bl: 72'h4030201000F0E0D0C0};
        tbl[3] = '{base: 4'h0, md: 1'b1, wn: 0, pat: 4'b1001, nb: 9, lat: 0,
                   b0: 72'h000706050403020100, bl: 72'h008786858483828180};

        rst = 1'b1; start = 1'b0; base_addr = '0; mode = 1'b0;
        fill_pattern();
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_read", avm_read, 1'b0);
        chk("rst_addr", avm_address, '0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_data", out_data, '0);
        rst = 1'b0;

        // Directed vector table
        for (int t = 0; t < 4; t++) begin
            fill_pattern();
            wait_n = tbl[t].wn;
            resp_delay = 0;
            rdy_rand = 1'b0;
            rdy_pat = tbl[t].pat;
            push_job(tbl[t].base, tbl[t].md);
            launch(tbl[t].base, tbl[t].md);
            wait_done(1000, "job_timeout");
            n_jobs++;
            chk("beat_count", n_beats, tbl[t].nb);
            chk("first_beat", first_d, tbl[t].b0);
            chk("last_beat", last_d, tbl[t].bl);
            chk("beats_left", exp_q.size(), 0);
            chk("addrs_left", addr_q.size(), 0);
            if (tbl[t].lat != 0) chk("latency", first_cyc - start_cyc, tbl[t].lat);
        end

        // start held high across a whole job: re-accept only in the IDLE after FIN
        fill_pattern();
        wait_n = 0; rdy_pat = 4'hF;
        push_job(4'h3, 1'b0);
        push_job(4'h3, 1'b0);
        done0 = n_done;
        @(negedge clk); #2;
        base_addr = 4'h3; mode = 1'b0; start = 1'b1; n_beats = 0;
        wait_done(1000, "held_job1_timeout");
        n_jobs++;
        @(negedge clk); #2;
        chk("held_idle_busy", busy, 1'b0);
        chk("held_idle_read", avm_read, 1'b0);
        @(negedge clk); #2;
        chk("held_second_accept", busy, 1'b1);
        for (i = 0; i < 1000; i++) begin
            @(negedge clk); #2;
            if (done) break;
            start = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        chk("held_job2_timeout", i < 1000, 1'b1);
        n_jobs++;
        repeat (3) @(negedge clk);
        #2;
        chk("held_busy_after", busy, 1'b0);
        chk("held_done_count", n_done - done0, 2);
        chk("held_beats_left", exp_q.size(), 0);

        // reset in RESP after 4 rows, with a stray readdatavalid arriving afterwards
        fill_pattern();
        wait_n = 0; resp_delay = 3;
        for (int r = 0; r < 5; r++) addr_q.push_back(AW'(r));
        done0 = n_done;
        acc0 = n_acc;
        launch(4'h0, 1'b0);
        for (i = 0; i < 400; i++) begin
            @(negedge clk); #2;
            if (n_acc >= acc0 + 5) break;
        end
        chk("rst_setup_timeout", i < 400, 1'b1);
        @(negedge clk); #2;
        chk("busy_in_resp", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk); #2;
        chk("read_after_rst", avm_read, 1'b0);
        chk("busy_after_rst", busy, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #2;
            chk("idle_after_abort_busy", busy, 1'b0);
            chk("idle_after_abort_read", avm_read, 1'b0);
        end
        chk("abort_no_done", n_done - done0, 0);
        chk("abort_addrs_left", addr_q.size(), 0);
        resp_delay = 0;
        push_job(4'h0, 1'b0);
        launch(4'h0, 1'b0);
        wait_done(1000, "post_rst_timeout");
        n_jobs++;
        chk("post_rst_first", first_d, 72'h877767574737271707);
        chk("post_rst_beats", n_beats, 8);

        // Randomized jobs against the reference model
        for (int t = 0; t < 8; t++) begin
            logic [AW-1:0] rb;
            logic          rm;
            fill_random();
            rb = AW'($urandom_range(0, 15));
            rm = 1'($urandom_range(0, 1));
            wait_n = $urandom_range(0, 2);
            resp_delay = $urandom_range(0, 2);
            rdy_rand = 1'b1;
            push_job(rb, rm);
            launch(rb, rm);
            wait_done(2000, "rand_job_timeout");
            n_jobs++;
            chk("rand_beat_count", n_beats, rm ? NR : L);
            chk("rand_beats_left", exp_q.size(), 0);
            chk("rand_addrs_left", addr_q.size(), 0);
        end
        rdy_rand = 1'b0;

        repeat (3) @(negedge clk);
        chk("done_total", n_done, n_jobs);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
